nios_system_onchip_memory_arbiter: RTL and testbench

Two-master round-robin arbiter sharing the single-port 2048×32 on-chip memory between two Avalon-MM requesters, e.g. Nios II data master and a DMA or accelerator. It sits between the interconnect and the memory's slave port. It converts the memory's fixed one-cycle read latency into per-master `readdatavalid` pulses and stalls losers with `waitrequest`. A saturating contention counter is exported for profiling.

---
 rtl/nios_system_pkg.sv | 18 +
 rtl/nios_system_rr_arbiter2.sv | 31 +++
 rtl/nios_system_onchip_memory_arbiter.sv | 127 ++++++++++++
 tb/tb_nios_system_onchip_memory_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_pkg.sv
// Shared types and default widths for the Nios system on-chip memory share.
package nios_system_pkg;

  localparam int DEFAULT_ADDR_W = 11;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  // One slot of the read-return pipeline: which master owns the returning word.
  typedef struct packed {
    logic       valid;
    master_id_t id;
  } read_tag_t;

endpackage

// File: rtl/nios_system_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered last-winner.
module nios_system_rr_arbiter2
  import nios_system_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  master_id_t last_q, last_d;

  // Grant: a lone requester wins; on a tie the master that did not win last time wins.
  always_comb begin
    gnt0_o = ~reset & req0_i & (~req1_i | (last_q == M1));
    gnt1_o = ~reset & req1_i & (~req0_i | (last_q == M0));
    last_d = last_q;
    if (gnt0_o)      last_d = M0;
    else if (gnt1_o) last_d = M1;
  end

  // Last-winner pointer; reset to M1 so M0 takes the first tie.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
    if (reset) last_q <= M1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/nios_system_onchip_memory_arbiter.sv
// Shares a single-port on-chip memory between two Avalon-MM masters with
// round-robin arbitration, per-master read-valid return and a contention counter.
module nios_system_onchip_memory_arbiter
  import nios_system_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,

  output logic [CNT_W-1:0]    contention_count
);

  logic m0_req, m1_req;
  logic gnt0, gnt1;
  logic accept_write, accept_read;

  read_tag_t tag_in;
  read_tag_t tag_q [READ_LATENCY];
  read_tag_t tag_tail;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  nios_system_rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign m0_waitrequest = reset | (m0_req & ~gnt0);
  assign m1_waitrequest = reset | (m1_req & ~gnt1);

  // Winner's command onto the memory port; master 0's fields sit there when idle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    accept_write   = 1'b0;
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (gnt1) begin
      accept_write   = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end else if (gnt0) begin
      accept_write   = m0_write;
    end
  end

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = accept_write;
  assign mem_clken      = ~reset;
  assign accept_read    = mem_chipselect & ~accept_write;

  // Tag entering the return pipeline for a read accepted this cycle.
  always_comb begin
    tag_in.valid = accept_read;
    tag_in.id    = gnt1 ? M1 : M0;
  end

  // Return pipeline matching the memory's read latency; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // A tag surfacing during reset belongs to a discarded read, so it is masked.
  assign tag_tail         = tag_q[READ_LATENCY-1];
  assign m0_readdatavalid = ~reset & tag_tail.valid & (tag_tail.id == M0);
  assign m1_readdatavalid = ~reset & tag_tail.valid & (tag_tail.id == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  // Saturating count of cycles in which both masters request.
  always_comb begin
    cnt_d = cnt_q;
    if (m0_req && m1_req && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Contention counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign contention_count = cnt_q;

endmodule

// File: tb/tb_nios_system_onchip_memory_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model (winner rule, reference memory, expected returns).
module tb_nios_system_onchip_memory_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;

  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [15:0]   contention_count;

  // Second instance with a 4-bit counter, sharing the master-side stimulus.
  logic          s_m0_waitrequest, s_m1_waitrequest, s_m0_readdatavalid, s_m1_readdatavalid;
  logic [DW-1:0] s_m0_readdata, s_m1_readdata, s_mem_readdata, s_mem_writedata;
  logic [AW-1:0] s_mem_address;
  logic [BW-1:0] s_mem_byteenable;
  logic          s_mem_chipselect, s_mem_write, s_mem_clken;
  logic [3:0]    s_contention_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_system_onchip_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .contention_count(contention_count)
  );

  nios_system_onchip_memory_arbiter #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(s_m0_waitrequest),
    .m0_readdata(s_m0_readdata), .m0_readdatavalid(s_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(s_m1_waitrequest),
    .m1_readdata(s_m1_readdata), .m1_readdatavalid(s_m1_readdatavalid),
    .mem_address(s_mem_address), .mem_byteenable(s_mem_byteenable),
    .mem_writedata(s_mem_writedata), .mem_chipselect(s_mem_chipselect),
    .mem_write(s_mem_write), .mem_clken(s_mem_clken),
    .mem_readdata(s_mem_readdata), .contention_count(s_contention_count)
  );

  assign s_mem_readdata = '0;

  // Behavioural single-port memory with one-cycle read latency, driven by the DUT.
  logic [DW-1:0] tb_mem [2048];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) tb_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= tb_mem[mem_address];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [2048];
  int            ref_last;   // master served most recently (0 or 1)
  int            ref_cnt;    // unsaturated contention cycles since reset
  bit            pend_v;     // read accepted at the previous edge
  int            pend_id;
  logic [DW-1:0] pend_d;

  // Values sampled in the last cycle, for directed checks.
  logic          smp_wait0, smp_wait1, smp_rdv0, smp_rdv1;
  logic [DW-1:0] smp_rdata;
  logic [15:0]   smp_cnt;
  logic [3:0]    smp_cnt_small;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: predict, compare mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic          r0, r1, w;
    int            win;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (reset)         win = -1;
    else if (r0 && r1) win = (ref_last == 0) ? 1 : 0;
    else if (r0)       win = 0;
    else if (r1)       win = 1;
    else               win = -1;

    @(negedge clk);
    check("wait0", {31'b0, m0_waitrequest}, {31'b0, reset | (r0 && win != 0)});
    check("wait1", {31'b0, m1_waitrequest}, {31'b0, reset | (r1 && win != 1)});
    check("cs", {31'b0, mem_chipselect}, {31'b0, win >= 0});
    check("mwr", {31'b0, mem_write},
          {31'b0, (win == 0) ? m0_write : (win == 1) ? m1_write : 1'b0});
    check("addr", {21'b0, mem_address}, {21'b0, (win == 1) ? m1_address : m0_address});
    check("be", {28'b0, mem_byteenable}, {28'b0, (win == 1) ? m1_byteenable : m0_byteenable});
    check("wdata", mem_writedata, (win == 1) ? m1_writedata : m0_writedata);
    check("clken", {31'b0, mem_clken}, {31'b0, ~reset});
    check("rdv0", {31'b0, m0_readdatavalid}, {31'b0, pend_v && !reset && pend_id == 0});
    check("rdv1", {31'b0, m1_readdatavalid}, {31'b0, pend_v && !reset && pend_id == 1});
    if (pend_v && !reset) begin
      check("rdata0", m0_readdata, pend_d);
      check("rdata1", m1_readdata, pend_d);
    end
    check("cnt", {16'b0, contention_count}, (ref_cnt > 65535) ? 32'hFFFF : ref_cnt);
    check("cnt4", {28'b0, s_contention_count}, (ref_cnt > 15) ? 32'd15 : ref_cnt);
    smp_wait0 = m0_waitrequest;  smp_wait1 = m1_waitrequest;
    smp_rdv0  = m0_readdatavalid; smp_rdv1 = m1_readdatavalid;
    smp_rdata = m0_readdata;     smp_cnt  = contention_count;
    smp_cnt_small = s_contention_count;

    @(posedge clk);
    if (reset) begin
      ref_last = 1;
      ref_cnt  = 0;
      pend_v   = 0;
    end else begin
      if (r0 && r1) ref_cnt++;
      pend_v = 0;
      if (win >= 0) begin
        ref_last = win;
        w  = (win == 1) ? m1_write : m0_write;
        a  = (win == 1) ? m1_address : m0_address;
        be = (win == 1) ? m1_byteenable : m0_byteenable;
        wd = (win == 1) ? m1_writedata : m0_writedata;
        if (w) begin
          for (int b = 0; b < BW; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          pend_v  = 1;
          pend_id = win;
          pend_d  = ref_mem[a];
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  int g0, g1;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      tb_mem[i]  = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    tb_mem[11'h010] = 32'hDEAD_0010; ref_mem[11'h010] = 32'hDEAD_0010;
    tb_mem[11'h7FF] = 32'h0;         ref_mem[11'h7FF] = 32'h0;
    ref_last = 1; ref_cnt = 0; pend_v = 0; pend_id = 0; pend_d = '0;
    m0_address = '0; m1_address = '0; m0_byteenable = '1; m1_byteenable = '1;
    m0_writedata = '0; m1_writedata = '0;
    idle();
    reset = 1;
    @(posedge clk); #1;   // bring DUT registers out of X before checking

    // Reset state, then a lone m0 read of a preloaded word.
    do_reset();
    m0_read = 1; m0_address = 11'h010;
    cycle();
    check("t1_wait0", {31'b0, smp_wait0}, 0);
    idle();
    cycle();
    check("t1_rdv0", {31'b0, smp_rdv0}, 1);
    check("t1_data", smp_rdata, 32'hDEAD_0010);
    check("t1_rdv1", {31'b0, smp_rdv1}, 0);

    // Tie between two reads: m0 first, m1 next, returns in order.
    do_reset();
    m0_read = 1; m0_address = 11'h001; m1_read = 1; m1_address = 11'h002;
    cycle();
    check("t2_wait0", {31'b0, smp_wait0}, 0);
    check("t2_wait1", {31'b0, smp_wait1}, 1);
    m0_read = 0;
    cycle();
    check("t2_wait1b", {31'b0, smp_wait1}, 0);
    check("t2_rdv0", {31'b0, smp_rdv0}, 1);
    check("t2_d0", smp_rdata, 32'h0101_0101 ^ 32'h5A5A_0000);
    m1_read = 0;
    cycle();
    check("t2_rdv1", {31'b0, smp_rdv1}, 1);
    check("t2_d1", smp_rdata, 32'h0202_0202 ^ 32'h5A5A_0000);
    check("t2_cnt", {16'b0, smp_cnt}, 1);

    // Both stream writes for 6 cycles: strict alternation.
    do_reset();
    g0 = 0; g1 = 0;
    m0_write = 1; m1_write = 1;
    for (int k = 0; k < 6; k++) begin
      m0_address = 11'h100 + 11'(k); m1_address = 11'h200 + 11'(k);
      m0_writedata = $urandom; m1_writedata = $urandom;
      cycle();
      check("t3_alt", {31'b0, smp_wait0}, (k % 2 == 0) ? 0 : 1);
      g0 += int'(!smp_wait0);
      g1 += int'(!smp_wait1);
    end
    idle();
    cycle();
    check("t3_cnt", {16'b0, smp_cnt}, 6);
    check("t3_g0", g0, 3);
    check("t3_g1", g1, 3);

    // Byte-lane write by m1, read back by m0.
    do_reset();
    m1_write = 1; m1_address = 11'h7FF; m1_byteenable = 4'b0101; m1_writedata = 32'hAABB_CCDD;
    cycle();
    idle();
    m0_read = 1; m0_address = 11'h7FF;
    cycle();
    idle();
    cycle();
    check("t4_rdv0", {31'b0, smp_rdv0}, 1);
    check("t4_data", smp_rdata, 32'h00BB_00DD);

    // Reset right after an accepted read: the return is discarded.
    do_reset();
    m0_read = 1; m0_address = 11'h010;
    cycle();
    idle();
    reset = 1;
    cycle();
    check("t5_rdv_rst", {31'b0, smp_rdv0}, 0);
    reset = 0;
    cycle();
    check("t5_rdv_after", {31'b0, smp_rdv0}, 0);
    m0_read = 1; m1_read = 1;
    cycle();
    check("t5_wait0", {31'b0, smp_wait0}, 0);
    check("t5_wait1", {31'b0, smp_wait1}, 1);
    idle();
    cycle();

    // Long contention: the 4-bit counter saturates at 15.
    do_reset();
    m0_read = 1; m1_read = 1;
    for (int k = 0; k < 20; k++) cycle();
    idle();
    cycle();
    check("t6_sat", {28'b0, smp_cnt_small}, 15);
    check("t6_cnt", {16'b0, smp_cnt}, 20);

    // Random traffic with occasional reset.
    m1_byteenable = '1;
    for (int k = 0; k < 400; k++) begin
      reset         = ($urandom_range(0, 39) == 0);
      m0_read       = 1'($urandom);
      m0_write      = ($urandom_range(0, 2) == 0);
      m1_read       = 1'($urandom);
      m1_write      = ($urandom_range(0, 2) == 0);
      m0_address    = ($urandom_range(0, 9) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
      m1_address    = ($urandom_range(0, 9) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
      m0_byteenable = 4'($urandom);
      m1_byteenable = 4'($urandom);
      m0_writedata  = $urandom;
      m1_writedata  = $urandom;
      cycle();
    end
    reset = 0;
    idle();
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
